// File: rtl/rom_streamer_if.sv
// rom_streamer_if: command, ROM and output-stream signals of rom_streamer.
// csum exists only when ROM_STREAM_CSUM_EN is defined.
interface rom_streamer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
`ifdef ROM_STREAM_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  modport slave (
    input  start, base_addr, length, rom_q, out_ready,
    output busy, done, rom_address, out_valid, out_data, out_addr
`ifdef ROM_STREAM_CSUM_EN
    , output csum
`endif
  );

  modport master (
    output start, base_addr, length, rom_q, out_ready,
    input  busy, done, rom_address, out_valid, out_data, out_addr
`ifdef ROM_STREAM_CSUM_EN
    , input csum
`endif
  );
endinterface

// File: rtl/rom_streamer.sv
// rom_streamer: streams a range of a latency-L synchronous ROM as valid/ready.
// Define ROM_STREAM_CSUM_EN to add a running XOR checksum (csum) of delivered words.
module rom_streamer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = ROM_LATENCY + 2
) (
  input logic           clock,
  input logic           reset,
  rom_streamer_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_base;
  logic [LW-1:0]     r_len;
  logic [LW-1:0]     r_issued;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_iss;

  logic [ROM_LATENCY-1:0] r_vld;
  logic [ADDR_W-1:0]      r_tadr [ROM_LATENCY];

  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [DATA_W-1:0] r_mdata [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_maddr [FIFO_DEPTH];

  logic              w_accept;
  logic              w_zero;
  logic              w_issue;
  logic              w_finish;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_credit;
  logic [CW:0]       w_occ;
  logic [ADDR_W-1:0] w_issue_addr;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.out_ready;
  assign w_push  = r_vld[ROM_LATENCY-1];

  // A slot being popped this cycle is already free for a new issue.
  assign w_occ    = {1'b0, r_inflight} + {1'b0, r_count}
                  - {{CW{1'b0}}, w_pop};
  assign w_credit = (w_occ < (CW+1)'(FIFO_DEPTH));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and per-cycle control decisions.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_zero       = 1'b0;
    w_issue      = 1'b0;
    w_finish     = 1'b0;
    w_issue_addr = r_base + r_issued[ADDR_W-1:0];
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.length == '0) begin
            w_zero = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_issue_addr = bus.base_addr;
            w_next       = RUN;
          end
        end
      end
      RUN: begin
        if (r_issued == r_len) w_next  = DRAIN;
        else if (w_credit)     w_issue = 1'b1;
      end
      DRAIN: begin
        if (r_inflight == '0 && r_count == '0) begin
          w_finish = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Transfer bookkeeping, ROM address and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rom_addr <= '0;
      r_iss      <= 1'b0;
    end else begin
      r_done <= w_zero | w_finish;
      r_iss  <= w_issue;
      if (w_accept) begin
        r_base <= bus.base_addr;
        r_len  <= bus.length;
        r_busy <= !w_zero;
      end
      if (w_finish) r_busy <= 1'b0;
      if (w_issue) begin
        r_rom_addr <= w_issue_addr;
        r_issued   <= w_accept ? LW'(1) : r_issued + 1'b1;
      end
    end
  end

  // Tag pipeline aligning each issued address with its ROM data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) r_tadr[i] <= '0;
    end else begin
      r_vld[0]  <= r_iss;
      r_tadr[0] <= r_rom_addr;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_tadr[i] <= r_tadr[i-1];
      end
    end
  end

  // Reads issued but not yet landed in the FIFO.
  always_ff @(posedge clock) begin
    if (reset) r_inflight <= '0;
    else       r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
  end

  // Output FIFO, first-word fall-through.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mdata[i] <= '0;
        r_maddr[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mdata[r_wp] <= bus.rom_q;
        r_maddr[r_wp] <= r_tadr[ROM_LATENCY-1];
        r_wp          <= f_inc(r_wp);
      end
      if (w_pop) r_rp <= f_inc(r_rp);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Credit accounting must never let the FIFO overflow.
  always_ff @(posedge clock) begin
    if (!reset && w_push && !w_pop) assert (r_count < CW'(FIFO_DEPTH));
  end

`ifdef ROM_STREAM_CSUM_EN
  logic [DATA_W-1:0] r_csum;

  // Running XOR of accepted words, restarted by each accepted start.
  always_ff @(posedge clock) begin
    if (reset)         r_csum <= '0;
    else if (w_accept) r_csum <= '0;
    else if (w_pop)    r_csum <= r_csum ^ bus.out_data;
  end

  assign bus.csum = r_csum;
`endif

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.rom_address = r_rom_addr;
  assign bus.out_valid   = w_valid;
  assign bus.out_data    = r_mdata[r_rp];
  assign bus.out_addr    = r_maddr[r_rp];
endmodule
